eth_rx_frame_filter: RTL

//  Consumes the received-byte stream read out of the MAC RX FIFO (data_from_buff side, MII 10 Mb/s path).

---
 rtl/eth_pkg.sv | 21 ++
 rtl/eth_crc32_byte.sv | 23 ++
 rtl/eth_rx_frame_filter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the RX frame filter and the TX path:
// framing bytes, CRC-32 constants, broadcast address and RX state encoding.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [47:0] ETH_BCAST_ADDR  = 48'hFFFF_FFFF_FFFF;
    localparam int          ETH_ADDR_BYTES  = 6;

    typedef enum logic [2:0] {
        SYNC,
        ADDR,
        FLUSH,
        FWD,
        DROP
    } rx_state_e;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB of the byte first).
// Purely combinational so RX and TX can chain it onto their own CRC register.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] stage [0:8];

    assign stage[0] = crc_in;

    // One shift/conditional-XOR per data bit, bit 0 of the byte processed first.
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign stage[gi+1] = {1'b0, stage[gi][31:1]}
                           ^ (ETH_CRC_POLY & {32{stage[gi][0] ^ data_in[gi]}});
    end

    assign crc_out = stage[8];

endmodule

// File: rtl/eth_rx_frame_filter.sv
// MII RX frame filter: strips preamble/SFD, filters on destination address,
// checks FCS and length, forwards accepted frames with an end-of-frame error
// flag and keeps saturating frame statistics.
module eth_rx_frame_filter
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [47:0]      cfg_mac_addr,
    input  logic             cfg_promisc,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_err,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_addr_drop,
    output logic [CNT_W-1:0] cnt_err
);

    // Length counter only needs to reach MAX_LEN+1, where it saturates.
    localparam int               LEN_W   = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rx_state_e        state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [47:0]      da_q, da_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
    logic [CNT_W-1:0] cnt_addr_drop_q, cnt_addr_drop_d;
    logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

    logic             out_load;
    logic             in_fire;
    logic [31:0]      crc_next;
    logic [LEN_W-1:0] len_inc;
    logic [47:0]      da_shift;
    logic             addr_match;
    logic             frame_bad;
    logic             ok_inc;
    logic             drop_inc;
    logic             err_inc;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data_in (in_data),
        .crc_out (crc_next)
    );

    // The output register may take a new byte whenever it is empty or being drained.
    assign out_load   = ~out_valid_q | out_ready;
    assign in_fire    = in_valid & in_ready;
    assign len_inc    = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
    assign da_shift   = {da_q[39:0], in_data};
    assign addr_match = (da_shift == cfg_mac_addr) | (da_shift == ETH_BCAST_ADDR) | cfg_promisc;
    assign frame_bad  = (crc_next != ETH_CRC_RESIDUE) | (len_inc < LEN_MIN) | (len_inc > LEN_MAX);

    // Input is stalled while the buffered DA is replayed, and in FWD only when the output cannot load.
    always_comb begin
        case (state_q)
            FLUSH:   in_ready = 1'b0;
            FWD:     in_ready = out_load;
            default: in_ready = 1'b1;
        endcase
    end

    // Next-state, datapath and output-register update for the frame FSM.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        len_d       = len_q;
        da_d        = da_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        ok_inc      = 1'b0;
        drop_inc    = 1'b0;
        err_inc     = 1'b0;

        // A consumed byte empties the register unless something reloads it below.
        if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_err_d   = 1'b0;
        end

        case (state_q)
            SYNC: begin
                if (in_fire) begin
                    if (in_last) begin
                        err_inc = 1'b1;
                    end else if (in_data == ETH_SFD) begin
                        state_d = ADDR;
                        crc_d   = ETH_CRC_INIT;
                        len_d   = '0;
                    end else if (in_data != ETH_PREAMBLE) begin
                        state_d = DROP;
                    end
                end
            end
            ADDR: begin
                if (in_fire) begin
                    da_d  = da_shift;
                    crc_d = crc_next;
                    len_d = len_inc;
                    if (in_last) begin
                        state_d = SYNC;
                        err_inc = 1'b1;
                    end else if (len_q == LEN_W'(ETH_ADDR_BYTES - 1)) begin
                        idx_d = '0;
                        if (addr_match) begin
                            state_d = FLUSH;
                        end else begin
                            state_d  = DROP;
                            drop_inc = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                // DA buffer is shifted out MSB byte first, i.e. in wire order.
                if (out_load) begin
                    out_data_d  = da_q[47:40];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_err_d   = 1'b0;
                    da_d        = {da_q[39:0], 8'h00};
                    idx_d       = idx_q + 1'b1;
                    if (idx_q == 3'(ETH_ADDR_BYTES - 1)) begin
                        state_d = FWD;
                    end
                end
            end
            FWD: begin
                if (in_fire) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    out_last_d  = in_last;
                    out_err_d   = in_last & frame_bad;
                    crc_d       = crc_next;
                    len_d       = len_inc;
                    if (in_last) begin
                        state_d = SYNC;
                        if (frame_bad) begin
                            err_inc = 1'b1;
                        end else begin
                            ok_inc = 1'b1;
                        end
                    end
                end
            end
            DROP: begin
                if (in_fire && in_last) begin
                    state_d = SYNC;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    // Saturating statistics counters.
    always_comb begin
        cnt_ok_d        = ok_inc   ? sat_inc(cnt_ok_q)        : cnt_ok_q;
        cnt_addr_drop_d = drop_inc ? sat_inc(cnt_addr_drop_q) : cnt_addr_drop_q;
        cnt_err_d       = err_inc  ? sat_inc(cnt_err_q)       : cnt_err_q;
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= SYNC;
            crc_q           <= ETH_CRC_INIT;
            len_q           <= '0;
            da_q            <= '0;
            idx_q           <= '0;
            out_data_q      <= 8'h00;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_err_q       <= 1'b0;
            cnt_ok_q        <= '0;
            cnt_addr_drop_q <= '0;
            cnt_err_q       <= '0;
        end else begin
            state_q         <= state_d;
            crc_q           <= crc_d;
            len_q           <= len_d;
            da_q            <= da_d;
            idx_q           <= idx_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            out_err_q       <= out_err_d;
            cnt_ok_q        <= cnt_ok_d;
            cnt_addr_drop_q <= cnt_addr_drop_d;
            cnt_err_q       <= cnt_err_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_err       = out_err_q;
    assign cnt_ok        = cnt_ok_q;
    assign cnt_addr_drop = cnt_addr_drop_q;
    assign cnt_err       = cnt_err_q;

endmodule
